// File: rtl/mixcol_multi.sv
// Multi-block AES MixColumns engine: reads NUM_BLOCKS states over the shared SRAM port,
// mixes COLS_PER_CYC columns per cycle and writes each result back. MIXCOL_INV_EN adds inverse.
module mixcol_multi #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned SRC_ADDR     = 32,
  parameter int unsigned DST_ADDR     = 32,
  parameter int unsigned ADDR_STRIDE  = 16,
  parameter int unsigned NUM_BLOCKS   = 1,
  parameter int unsigned READ_LAT     = 1,
  parameter int unsigned COLS_PER_CYC = 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              mixcol_enable,
  input  logic              inv_mode,
  input  logic [127:0]      sramReadValue,
  output logic              sramRead,
  output logic              sramWrite,
  output logic [ADDR_W-1:0] sramAddr,
  output logic [127:0]      sramWriteValue,
  output logic              mixcol_busy,
  output logic              mixcol_finished
);

  localparam int unsigned CompCycles = 4 / COLS_PER_CYC;
  localparam logic [2:0]  WaitLast   = 3'(READ_LAT - 1);
  localparam logic [2:0]  CompLast   = 3'(CompCycles - 1);
  localparam logic [7:0]  BlkLast    = 8'(NUM_BLOCKS - 1);

  typedef enum logic [2:0] {StIdle, StRead, StWait, StComp, StWrite, StDone} state_e;

  state_e        state_q;
  logic [7:0]    k_q;
  logic [2:0]    cnt_q;
  logic [127:0]  data_q;
  logic [127:0]  data_mixed;
  logic          inv_sel;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_fwd(input logic [31:0] c);
    logic [7:0] a [4];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) a[i] = c[31-8*i -: 8];
    for (int i = 0; i < 4; i++) begin
      r[31-8*i -: 8] = xt(a[i]) ^ xt(a[(i+1)%4]) ^ a[(i+1)%4] ^ a[(i+2)%4] ^ a[(i+3)%4];
    end
    return r;
  endfunction

`ifdef MIXCOL_INV_EN
  logic mode_q;
  assign inv_sel = mode_q;

  function automatic logic [31:0] mix_inv(input logic [31:0] c);
    logic [7:0] x1 [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      x1[i] = c[31-8*i -: 8];
      x2[i] = xt(x1[i]);
      x4[i] = xt(x2[i]);
      x8[i] = xt(x4[i]);
    end
    // Row i: 0E*a[i] ^ 0B*a[i+1] ^ 0D*a[i+2] ^ 09*a[i+3]
    for (int i = 0; i < 4; i++) begin
      r[31-8*i -: 8] = (x8[i] ^ x4[i] ^ x2[i])
                     ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ x1[(i+1)%4])
                     ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ x1[(i+2)%4])
                     ^ (x8[(i+3)%4] ^ x1[(i+3)%4]);
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mode_q <= 1'b0;
    end else if (state_q == StIdle && mixcol_enable) begin
      mode_q <= inv_mode;
    end
  end
`else
  logic unused_inv_mode;
  assign unused_inv_mode = inv_mode;
  assign inv_sel = 1'b0;

  function automatic logic [31:0] mix_inv(input logic [31:0] c);
    return mix_fwd(c);
  endfunction
`endif

  function automatic logic [ADDR_W-1:0] blk_addr(input int unsigned base, input logic [7:0] k);
    return ADDR_W'(base + 32'(k) * ADDR_STRIDE);
  endfunction

  // Mix the columns scheduled for this COMP cycle in place; column 0 first.
  always_comb begin
    data_mixed = data_q;
    for (int c = 0; c < int'(COLS_PER_CYC); c++) begin
      int idx;
      idx = int'(cnt_q) * int'(COLS_PER_CYC) + c;
      data_mixed[127-32*idx -: 32] = inv_sel ? mix_inv(data_q[127-32*idx -: 32])
                                             : mix_fwd(data_q[127-32*idx -: 32]);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q         <= StIdle;
      k_q             <= '0;
      cnt_q           <= '0;
      data_q          <= '0;
      sramRead        <= 1'b0;
      sramWrite       <= 1'b0;
      sramAddr        <= '0;
      sramWriteValue  <= '0;
      mixcol_busy     <= 1'b0;
      mixcol_finished <= 1'b0;
    end else begin
      sramRead       <= 1'b0;
      sramWrite      <= 1'b0;
      sramWriteValue <= '0;
      unique case (state_q)
        StIdle: begin
          if (mixcol_enable) begin
            state_q     <= StRead;
            k_q         <= '0;
            sramRead    <= 1'b1;
            sramAddr    <= blk_addr(SRC_ADDR, 8'd0);
            mixcol_busy <= 1'b1;
          end
        end
        StRead, StWait, StComp: begin
          if (!mixcol_enable) begin
            state_q     <= StIdle;
            sramAddr    <= '0;
            mixcol_busy <= 1'b0;
          end else if (state_q == StRead) begin
            state_q <= StWait;
            cnt_q   <= '0;
          end else if (state_q == StWait) begin
            if (cnt_q == WaitLast) begin
              data_q  <= sramReadValue;
              state_q <= StComp;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end else begin
            data_q <= data_mixed;
            if (cnt_q == CompLast) begin
              state_q        <= StWrite;
              sramWrite      <= 1'b1;
              sramAddr       <= blk_addr(DST_ADDR, k_q);
              sramWriteValue <= data_mixed;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        StWrite: begin
          k_q <= k_q + 8'd1;
          if (!mixcol_enable) begin
            state_q     <= StIdle;
            sramAddr    <= '0;
            mixcol_busy <= 1'b0;
          end else if (k_q == BlkLast) begin
            state_q         <= StDone;
            sramAddr        <= '0;
            mixcol_busy     <= 1'b0;
            mixcol_finished <= 1'b1;
          end else begin
            state_q  <= StRead;
            sramRead <= 1'b1;
            sramAddr <= blk_addr(SRC_ADDR, k_q + 8'd1);
          end
        end
        StDone: begin
          if (!mixcol_enable) begin
            state_q         <= StIdle;
            mixcol_finished <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mixcol_multi.sv
// Directed bench for mixcol_multi: default instance, 3-block instance, 4-column/2-latency instance.
module tb_mixcol_multi;

  logic clk, n_rst, inv;
  logic en_a, en_b, en_c;
  logic rd_a, rd_b, rd_c, wr_a, wr_b, wr_c;
  logic busy_a, busy_b, busy_c, fin_a, fin_b, fin_c;
  logic [15:0] addr_a, addr_b, addr_c;
  logic [127:0] rv_a, rv_b, rv_c, wv_a, wv_b, wv_c, p_c;
  logic [127:0] mem_a [256];
  logic [127:0] mem_b [256];
  logic [127:0] mem_c [256];
  logic [127:0] wmem_a [256];
  logic [127:0] wmem_b [256];
  logic [127:0] wmem_c [256];
  int wcnt_a, wcnt_b, wcnt_c;
  logic ovl;
  int checks, fails;
  int n, nb;

  localparam logic [127:0] StIn   = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] StOut  = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] DbIn   = {4{32'hdb135345}};
  localparam logic [127:0] DbOut  = {4{32'h8e4da1bc}};
  localparam logic [127:0] OnesIn = {4{32'h01010101}};

  mixcol_multi u_a (
    .clk(clk), .n_rst(n_rst), .mixcol_enable(en_a), .inv_mode(inv), .sramReadValue(rv_a),
    .sramRead(rd_a), .sramWrite(wr_a), .sramAddr(addr_a), .sramWriteValue(wv_a),
    .mixcol_busy(busy_a), .mixcol_finished(fin_a)
  );

  mixcol_multi #(.NUM_BLOCKS(3)) u_b (
    .clk(clk), .n_rst(n_rst), .mixcol_enable(en_b), .inv_mode(inv), .sramReadValue(rv_b),
    .sramRead(rd_b), .sramWrite(wr_b), .sramAddr(addr_b), .sramWriteValue(wv_b),
    .mixcol_busy(busy_b), .mixcol_finished(fin_b)
  );

  mixcol_multi #(.COLS_PER_CYC(4), .READ_LAT(2)) u_c (
    .clk(clk), .n_rst(n_rst), .mixcol_enable(en_c), .inv_mode(inv), .sramReadValue(rv_c),
    .sramRead(rd_c), .sramWrite(wr_c), .sramAddr(addr_c), .sramWriteValue(wv_c),
    .mixcol_busy(busy_c), .mixcol_finished(fin_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM models: reads return data READ_LAT cycles after the strobe; writes go to a capture array.
  always @(posedge clk) begin
    if (rd_a) rv_a <= mem_a[addr_a[7:0]];
    if (rd_b) rv_b <= mem_b[addr_b[7:0]];
    if (rd_c) p_c <= mem_c[addr_c[7:0]];
    rv_c <= p_c;
    if (wr_a) begin wmem_a[addr_a[7:0]] <= wv_a; wcnt_a <= wcnt_a + 1; end
    if (wr_b) begin wmem_b[addr_b[7:0]] <= wv_b; wcnt_b <= wcnt_b + 1; end
    if (wr_c) begin wmem_c[addr_c[7:0]] <= wv_c; wcnt_c <= wcnt_c + 1; end
    if ((rd_a && wr_a) || (rd_b && wr_b) || (rd_c && wr_c)) ovl <= 1'b1;
  end

  function automatic logic busy_of(input int w);
    return (w == 0) ? busy_a : (w == 1) ? busy_b : busy_c;
  endfunction

  function automatic logic fin_of(input int w);
    return (w == 0) ? fin_a : (w == 1) ? fin_b : fin_c;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  // Steps until finished rises; rn = edges taken (0 if the bound expires), rb = busy cycles seen.
  task automatic run(input int w, input int bound, output int rn, output int rb);
    rn = 0;
    rb = 0;
    for (int i = 1; i <= bound; i++) begin
      @(posedge clk); #1;
      if (busy_of(w)) rb++;
      if (fin_of(w)) begin rn = i; break; end
    end
  endtask

  initial begin
    checks = 0; fails = 0; ovl = 1'b0;
    n_rst = 1'b0; inv = 1'b0; en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    mem_a[32] = StIn;
    mem_b[32] = DbIn; mem_b[48] = DbIn; mem_b[64] = DbIn;
    mem_c[32] = OnesIn;
    #12;
    chk("reset_ctrl", {rd_a, wr_a, busy_a, fin_a, addr_a}, '0);
    chk("reset_wdata", wv_a, '0);
    @(negedge clk) n_rst = 1'b1;
    step(1);

    // Forward, single block; inv_mode flipped mid-run must be ignored.
    en_a = 1'b1;
    step(1);
    chk("first_read", {rd_a, busy_a, addr_a}, {1'b1, 1'b1, 16'd32});
    inv = 1'b1;
    run(0, 40, n, nb);
    chk("fwd_latency", 128'(n + 1), 128'd8);
    chk("fwd_busy", 128'(nb), 128'd6);
    chk("fwd_data", wmem_a[32], StOut);
    chk("fwd_wcnt", 128'(wcnt_a), 128'd1);
    step(1);
    chk("done_hold", fin_a, 1'b1);
    en_a = 1'b0;
    step(1);
    chk("done_release", {fin_a, busy_a}, 2'b00);

    // inv_mode=1 latched at start: inverse when built in, else forward.
`ifdef MIXCOL_INV_EN
    mem_a[32] = StOut;
`else
    mem_a[32] = DbIn;
`endif
    inv = 1'b1;
    en_a = 1'b1;
    run(0, 40, n, nb);
    chk("inv_latency", 128'(n), 128'd8);
`ifdef MIXCOL_INV_EN
    chk("inv_data", wmem_a[32], StIn);
`else
    chk("inv_ignored", wmem_a[32], DbOut);
`endif
    en_a = 1'b0;
    step(1);

    // Abort during COMP: no write, idle next cycle.
    inv = 1'b0;
    en_a = 1'b1;
    step(3);
    chk("abort_busy", busy_a, 1'b1);
    en_a = 1'b0;
    step(1);
    chk("abort_idle", {busy_a, fin_a, rd_a, wr_a}, 4'b0000);
    step(6);
    chk("abort_nowrite", 128'(wcnt_a), 128'd2);
    chk("abort_nofin", fin_a, 1'b0);

    // Async reset during WAIT, then restart from block 0.
    mem_a[32] = StIn;
    en_a = 1'b1;
    step(2);
    chk("wait_busy", busy_a, 1'b1);
    n_rst = 1'b0;
    #1;
    chk("rst_ctrl", {rd_a, wr_a, busy_a, fin_a, addr_a}, '0);
    chk("rst_wdata", wv_a, '0);
    @(negedge clk) n_rst = 1'b1;
    run(0, 40, n, nb);
    chk("restart_latency", 128'(n), 128'd8);
    chk("restart_busy", 128'(nb), 128'd7);
    chk("restart_data", wmem_a[32], StOut);
    chk("restart_wcnt", 128'(wcnt_a), 128'd3);
    en_a = 1'b0;
    step(1);

    // Three blocks at stride 16.
    en_b = 1'b1;
    run(1, 60, n, nb);
    chk("multi_latency", 128'(n), 128'd22);
    chk("multi_busy", 128'(nb), 128'd21);
    chk("multi_blk0", wmem_b[32], DbOut);
    chk("multi_blk1", wmem_b[48], DbOut);
    chk("multi_blk2", wmem_b[64], DbOut);
    chk("multi_wcnt", 128'(wcnt_b), 128'd3);
    en_b = 1'b0;
    step(1);
    chk("multi_release", fin_b, 1'b0);

    // Four columns per cycle, read latency 2.
    en_c = 1'b1;
    run(2, 40, n, nb);
    chk("wide_latency", 128'(n), 128'd6);
    chk("wide_busy", 128'(nb), 128'd5);
    chk("wide_ones", wmem_c[32], OnesIn);
    en_c = 1'b0;
    step(1);
    mem_c[32] = StIn;
    en_c = 1'b1;
    run(2, 40, n, nb);
    chk("wide_data", wmem_c[32], StOut);
    chk("wide_wcnt", 128'(wcnt_c), 128'd2);
    en_c = 1'b0;
    step(1);

    chk("rd_wr_exclusive", ovl, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
